// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Mock8080 instruction fetch path: FSM state
// encoding, default address width, instruction length codes, the opcode
// mask/match patterns that classify 8080 instruction lengths, and the
// instruction bundle payload.
package fetch_unit_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_e;

  // Instruction length in bytes
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Three-byte families: 00rr0001 (LXI), 11ccc010 (Jcc), 11ccc100 (Ccc),
  // 11xx1101 (CALL and the DD/ED/FD call aliases)
  localparam logic [7:0] LXI_MASK   = 8'hCF;
  localparam logic [7:0] LXI_MATCH  = 8'h01;
  localparam logic [7:0] COND_MASK  = 8'hC7;
  localparam logic [7:0] JCC_MATCH  = 8'hC2;
  localparam logic [7:0] CCC_MATCH  = 8'hC4;
  localparam logic [7:0] CALL_MASK  = 8'hCF;
  localparam logic [7:0] CALL_MATCH = 8'hCD;

  // Three-byte singletons
  localparam logic [7:0] OP_SHLD    = 8'h22;
  localparam logic [7:0] OP_LHLD    = 8'h2A;
  localparam logic [7:0] OP_STA     = 8'h32;
  localparam logic [7:0] OP_LDA     = 8'h3A;
  localparam logic [7:0] OP_JMP     = 8'hC3;
  localparam logic [7:0] OP_JMP_ALT = 8'hCB;

  // Two-byte families: 00rrr110 (MVI), 11xxx110 (immediate ALU)
  localparam logic [7:0] IMM_MASK   = 8'hC7;
  localparam logic [7:0] MVI_MATCH  = 8'h06;
  localparam logic [7:0] ALUI_MATCH = 8'hC6;

  // Two-byte singletons
  localparam logic [7:0] OP_OUT     = 8'hD3;
  localparam logic [7:0] OP_IN      = 8'hDB;

  // Opcode bundle presented to the decoder (address travels separately
  // because its width is a module parameter)
  typedef struct packed {
    logic [BYTE_W-1:0] opcode;
    logic [BYTE_W-1:0] op_lo;
    logic [BYTE_W-1:0] op_hi;
    logic [1:0]        len;
  } instr_bundle_t;

  localparam instr_bundle_t BUNDLE_RST = '{
    opcode: 8'h00,
    op_lo:  8'h00,
    op_hi:  8'h00,
    len:    LEN_1
  };

  function automatic logic op_match(input logic [7:0] op,
                                    input logic [7:0] mask,
                                    input logic [7:0] match);
    return (op & mask) == match;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational 8080 instruction length decoder.
// Ports:
//   opcode : opcode byte
//   len_c  : instruction length in bytes (1..3), combinational
module instr_len_decode
  import fetch_unit_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len_c
);

  logic is_len3_c;
  logic is_len2_c;

  // Length classes; a byte matches at most one class, len3 checked first
  always_comb begin
    is_len3_c = op_match(opcode, LXI_MASK,  LXI_MATCH)  ||
                op_match(opcode, COND_MASK, JCC_MATCH)  ||
                op_match(opcode, COND_MASK, CCC_MATCH)  ||
                op_match(opcode, CALL_MASK, CALL_MATCH) ||
                (opcode == OP_SHLD) || (opcode == OP_LHLD) ||
                (opcode == OP_STA)  || (opcode == OP_LDA)  ||
                (opcode == OP_JMP)  || (opcode == OP_JMP_ALT);

    is_len2_c = op_match(opcode, IMM_MASK, MVI_MATCH)  ||
                op_match(opcode, IMM_MASK, ALUI_MATCH) ||
                (opcode == OP_OUT) || (opcode == OP_IN);

    len_c = LEN_1;
    if (is_len3_c) begin
      len_c = LEN_3;
    end else if (is_len2_c) begin
      len_c = LEN_2;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Mock8080 instruction fetch stage. Owns the PC, issues one BRAM read per
// mem_step strobe, assembles opcode plus operand bytes and hands the
// complete instruction to the decoder over valid/ready.
// Ports:
//   clk_qzt, rst          : clock, async active-high reset
//   run                   : fetch enable, sampled before each new instruction
//   mem_step              : single-cycle BRAM access strobe
//   mem_data              : registered BRAM read data
//   mem_en, mem_addr      : BRAM enable and read address
//   pc_load, pc_new       : redirect request and target
//   instr_valid/ready     : bundle handshake
//   instr_opcode/op_lo/op_hi/len/pc : instruction bundle
//   pc_out                : current PC (debug)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_qzt,
  input  logic              rst,
  input  logic              run,
  input  logic              mem_step,
  input  logic [7:0]        mem_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_op_lo,
  output logic [7:0]        instr_op_hi,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_out
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  instr_bundle_t      bundle_q, bundle_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic               valid_d;
  logic [1:0]         dec_len_c;
  logic [1:0]         cap_len_c;
  logic               more_c;

  instr_len_decode u_len_dec (
    .opcode (mem_data),
    .len_c  (dec_len_c)
  );

  // State register and registered outputs
  always_ff @(posedge clk_qzt or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      idx_q       <= '0;
      bundle_q    <= BUNDLE_RST;
      ipc_q       <= RESET_PC;
      mem_en      <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      bundle_q    <= bundle_d;
      ipc_q       <= ipc_d;
      mem_en      <= mem_en_d;
      mem_addr    <= mem_addr_d;
      instr_valid <= valid_d;
    end
  end

  // Next-state, PC and bundle assembly
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    bundle_d = bundle_q;
    ipc_d    = ipc_q;

    // Length comes straight from the decoder while capturing the opcode
    cap_len_c = (idx_q == '0) ? dec_len_c : bundle_q.len;
    more_c    = (3'(idx_q) + 3'd1) < 3'(cap_len_c);

    if (pc_load) begin
      // Redirect wins over everything, including a same-cycle mem_step
      pc_d    = pc_new;
      idx_d   = '0;
      state_d = run ? S_REQ : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            idx_d   = '0;
            state_d = S_REQ;
          end
        end

        S_REQ: begin
          if (mem_step) begin
            state_d = S_CAP;
          end
        end

        S_CAP: begin
          pc_d = pc_q + ADDR_W'(1);
          case (idx_q)
            2'd0: begin
              bundle_d.opcode = mem_data;
              bundle_d.op_lo  = 8'h00;
              bundle_d.op_hi  = 8'h00;
              bundle_d.len    = dec_len_c;
              ipc_d           = pc_q;
            end
            2'd1:    bundle_d.op_lo = mem_data;
            default: bundle_d.op_hi = mem_data;
          endcase
          if (more_c) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_REQ;
          end else begin
            state_d = S_OUT;
          end
        end

        S_OUT: begin
          if (instr_ready) begin
            idx_d   = '0;
            state_d = run ? S_REQ : S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Outputs registered from the next state so they line up with it
    mem_en_d   = (state_d == S_REQ);
    mem_addr_d = pc_d;
    valid_d    = (state_d == S_OUT);
  end

  assign instr_opcode = bundle_q.opcode;
  assign instr_op_lo  = bundle_q.op_lo;
  assign instr_op_hi  = bundle_q.op_hi;
  assign instr_len    = bundle_q.len;
  assign instr_pc     = ipc_q;
  assign pc_out       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a read-first BRAM model and a
// scoreboard of expected instruction bundles.
module tb_fetch_unit;

  logic       clk_qzt;
  logic       rst;
  logic       run;
  logic       mem_step;
  logic [7:0] mem_data;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic       pc_load;
  logic [7:0] pc_new;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_op_lo;
  logic [7:0] instr_op_hi;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic [7:0] pc_out;

  typedef struct {
    logic [7:0] opcode;
    logic [7:0] op_lo;
    logic [7:0] op_hi;
    logic [1:0] len;
    logic [7:0] ipc;
    logic [7:0] pcout;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_exp;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         step_period = 0;
  int         step_cnt = 0;
  logic       man_step = 1'b0;
  int         t1 = 0;
  int         t2 = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk_qzt      (clk_qzt),
    .rst          (rst),
    .run          (run),
    .mem_step     (mem_step),
    .mem_data     (mem_data),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .pc_load      (pc_load),
    .pc_new       (pc_new),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op_lo  (instr_op_lo),
    .instr_op_hi  (instr_op_hi),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .pc_out       (pc_out)
  );

  initial begin
    clk_qzt = 1'b0;
    forever #5 clk_qzt = ~clk_qzt;
  end

  always @(posedge clk_qzt) cyc <= cyc + 1;

  // Read-first registered BRAM
  always_ff @(posedge clk_qzt) begin
    if (mem_en && mem_step) mem_data <= mem[mem_addr];
  end

  // Step strobe: periodic pulse OR a manual single pulse
  initial begin
    mem_step = 1'b0;
    forever begin
      @(posedge clk_qzt);
      #2;
      if (step_period == 0) begin
        step_cnt = 0;
        mem_step = man_step;
      end else begin
        step_cnt = step_cnt + 1;
        if (step_cnt >= step_period) begin
          step_cnt = 0;
          mem_step = 1'b1;
        end else begin
          mem_step = man_step;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every cycle a bundle is offered, compare it to the scoreboard head
  always @(negedge clk_qzt) begin
    if (!rst && instr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", 32'(sb.size()), 32'd1);
      end else begin
        mon_exp = sb[0];
        chk("opcode",   32'(instr_opcode), 32'(mon_exp.opcode));
        chk("op_lo",    32'(instr_op_lo),  32'(mon_exp.op_lo));
        chk("op_hi",    32'(instr_op_hi),  32'(mon_exp.op_hi));
        chk("len",      32'(instr_len),    32'(mon_exp.len));
        chk("instr_pc", 32'(instr_pc),     32'(mon_exp.ipc));
        chk("pc_out",   32'(pc_out),       32'(mon_exp.pcout));
        if (instr_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_qzt);
    #1;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [1:0] len, input logic [7:0] ipc, input logic [7:0] pco);
    exp_t e;
    e.opcode = op; e.op_lo = lo; e.op_hi = hi; e.len = len; e.ipc = ipc; e.pcout = pco;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_en"},   32'(mem_en),       32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr),     32'h00);
    chk({tag, "_valid"},    32'(instr_valid),  32'd0);
    chk({tag, "_opcode"},   32'(instr_opcode), 32'h00);
    chk({tag, "_op_lo"},    32'(instr_op_lo),  32'h00);
    chk({tag, "_op_hi"},    32'(instr_op_hi),  32'h00);
    chk({tag, "_len"},      32'(instr_len),    32'd1);
    chk({tag, "_instr_pc"}, 32'(instr_pc),     32'h00);
    chk({tag, "_pc_out"},   32'(pc_out),       32'h00);
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int k = 0;
    while (!instr_valid && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_access(input int max_cyc, input string tag);
    int k = 0;
    logic seen = 1'b0;
    while (!seen && k < max_cyc) begin
      @(negedge clk_qzt);
      seen = mem_en && mem_step;
      k++;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_sb(input int n, input int max_cyc, input string tag);
    int k = 0;
    while (sb.size() > n && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 32'(sb.size()), 32'(n));
  endtask

  // Wait for a bundle, hold it for 'hold' cycles, then accept it
  task automatic accept(input int hold, input string tag);
    wait_valid(100, {tag, "_valid"});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_held_valid"}, 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr_ready = 1'b0; pc_load = 1'b0; pc_new = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h3E; mem[8'h01] = 8'h42;
    mem[8'h02] = 8'hC3; mem[8'h03] = 8'h10; mem[8'h04] = 8'h00;
    mem[8'hFE] = 8'h32; mem[8'hFF] = 8'h34;
    mem[8'h20] = 8'hCD; mem[8'h21] = 8'h30; mem[8'h22] = 8'h00;

    repeat (3) tick();
    check_reset_vals("por");

    // Reset asserted while capturing
    rst = 1'b0; run = 1'b1; step_period = 4;
    wait_access(50, "first_access");
    @(posedge clk_qzt);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_in_cap");
    tick();
    rst = 1'b0;
    tick();
    chk("restart_mem_en",   32'(mem_en),   32'd1);
    chk("restart_mem_addr", 32'(mem_addr), 32'h00);

    // MVI A,42 at 00
    push(8'h3E, 8'h42, 8'h00, 2'd2, 8'h00, 8'h02);
    accept(0, "mvi");

    // JMP 0010 at 02, decoder stalls 5 cycles; idle afterwards
    push(8'hC3, 8'h10, 8'h00, 2'd3, 8'h02, 8'h05);
    run = 1'b0;
    accept(5, "jmp");
    repeat (6) tick();
    chk("jmp_idle_mem_en", 32'(mem_en), 32'd0);
    chk("jmp_idle_pc",     32'(pc_out), 32'h05);

    // Redirect while idle, then STA across the FF->00 wrap
    pc_load = 1'b1; pc_new = 8'hFE;
    tick();
    pc_load = 1'b0;
    chk("redir_pc_out",   32'(pc_out),      32'hFE);
    chk("redir_mem_addr", 32'(mem_addr),    32'hFE);
    chk("redir_mem_en",   32'(mem_en),      32'd0);
    chk("redir_valid",    32'(instr_valid), 32'd0);
    push(8'h32, 8'h34, 8'h3E, 2'd3, 8'hFE, 8'h01);
    run = 1'b1;
    tick();
    run = 1'b0;
    accept(0, "wrap");
    repeat (4) tick();
    chk("wrap_idle_mem_en", 32'(mem_en), 32'd0);

    // Redirect in S_REQ mid-CALL with a coincident step
    step_period = 0;
    pc_load = 1'b1; pc_new = 8'h20; run = 1'b1;
    tick();
    pc_load = 1'b0;
    chk("call_req_en",   32'(mem_en),   32'd1);
    chk("call_req_addr", 32'(mem_addr), 32'h20);
    man_step = 1'b1;
    tick();
    man_step = 1'b0;
    chk("call_cap_en", 32'(mem_en), 32'd0);
    tick();
    chk("call_op1_en",   32'(mem_en),   32'd1);
    chk("call_op1_addr", 32'(mem_addr), 32'h21);
    chk("call_op1_pc",   32'(pc_out),   32'h21);
    pc_load = 1'b1; pc_new = 8'h10; man_step = 1'b1;
    tick();
    pc_load = 1'b0; man_step = 1'b0;
    chk("kill_mem_addr", 32'(mem_addr),    32'h10);
    chk("kill_mem_en",   32'(mem_en),      32'd1);
    chk("kill_valid",    32'(instr_valid), 32'd0);
    chk("kill_pc_out",   32'(pc_out),      32'h10);
    repeat (4) tick();
    chk("kill_still_no_valid", 32'(instr_valid), 32'd0);
    chk("kill_still_addr",     32'(mem_addr),    32'h10);

    // NOP stream at 10.., run dropped while the fourth NOP is captured
    for (int i = 0; i < 4; i++) push(8'h00, 8'h00, 8'h00, 2'd1, 8'(8'h10 + i), 8'(8'h11 + i));
    instr_ready = 1'b1;
    step_period = 2;
    wait_sb(3, 60, "nop_first");
    t1 = cyc;
    wait_sb(2, 60, "nop_second");
    t2 = cyc;
    chk("nop_interval", 32'(t2 - t1), 32'd4);
    wait_sb(1, 60, "nop_third");
    wait_access(20, "nop_last_access");
    @(posedge clk_qzt);
    #1;
    run = 1'b0;
    wait_sb(0, 20, "nop_last");
    repeat (6) tick();
    chk("stop_mem_en", 32'(mem_en),      32'd0);
    chk("stop_valid",  32'(instr_valid), 32'd0);
    chk("stop_pc_out", 32'(pc_out),      32'h14);
    instr_ready = 1'b0;
    step_period = 0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the 256-byte program/data BRAM in the Mock8080 datapath. It owns the program counter and drives the BRAM read address and enable. It captures the registered read-first data_out byte(s), determines the 8080 instruction length from the opcode, and presents a complete instruction (opcode plus 0-2 operand bytes) to the decoder over a valid/ready handshake. Memory accesses advance only on the single-cycle step strobe that gates the BRAM.

Parameters:
ADDR_W, 8, width of program counter and memory address (256-byte space)
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk_qzt  in  1  system (quartz) clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
run  in  1  fetch enable; sampled only before starting a new instruction
mem_step  in  1  one-clk_qzt-cycle pulse: the cycle in which the BRAM performs its access
mem_data  in  8  BRAM data_out (registered, valid the cycle after mem_step)
mem_en  out  1  BRAM enable
mem_addr  out  ADDR_W  BRAM read address
pc_load  in  1  redirect request (jump/call/ret from execute)
pc_new  in  ADDR_W  redirect target
instr_valid  out  1  instruction bundle valid
instr_ready  in  1  decoder accepts bundle
instr_opcode  out  8  opcode byte
instr_op_lo  out  8  first operand byte (0 if none)
instr_op_hi  out  8  second operand byte (0 if none)
instr_len  out  2  instruction length, 1..3
instr_pc  out  ADDR_W  address of the opcode byte
pc_out  out  ADDR_W  current PC (debug view)

Behaviour:
- Reset (async): state=S_IDLE, pc=RESET_PC, byte index=0, mem_en=0, mem_addr=RESET_PC, instr_valid=0, instr_opcode/op_lo/op_hi=0, instr_len=1, instr_pc=RESET_PC.
- S_IDLE: mem_en=0. If run=1, go to S_REQ with index=0.
- S_REQ: mem_en=1, mem_addr=pc. Wait for mem_step=1, then go to S_CAP.
- S_CAP: mem_en=0. Latch mem_data into byte[index] and increment pc (mod 2^ADDR_W).
  - If index=0: latch instr_pc=old pc and len=lookup(mem_data).
  - If index+1 < len: index++ and return to S_REQ. Otherwise go to S_OUT.
- S_OUT: instr_valid=1; bundle outputs stay stable until instr_ready=1. On handshake, clear instr_valid and set index=0. Go to S_REQ if run=1, else S_IDLE.
- mem_step is ignored outside S_REQ.
- Minimum latency for a 1-byte instruction: step at cycle t, capture at t+1, instr_valid at t+2. Each extra operand adds one S_REQ wait plus one capture cycle.
- Length lookup, with opcode bits o:
  - Length 3: 00rr0001 (LXI), 22, 2A, 32, 3A, C3, CB, 11ccc010 (Jcc), 11ccc100 (Ccc), CD, and 11xx1101 (DD/ED/FD).
  - Length 2: 00rrr110 (MVI), 11xxx110 (immediate ALU), D3, DB.
  - Everything else: length 1.
- Unused operand bytes read as 0.
- PC wrap: FF+1=00. A multi-byte instruction at FE or FF takes its operands from 00 onward.
- pc_load is accepted in any state and has the highest priority:
  - pc=pc_new, index=0, instr_valid=0 on the next cycle.
  - Next state is S_REQ if run=1, else S_IDLE.
  - Any partial fetch is discarded; a mem_step in the same cycle is ignored.
- If pc_load coincides with instr_valid&&instr_ready, the handshake counts as completed (decoder keeps the bundle) and the redirect still applies.
- run dropping mid-instruction does not abort: the instruction completes and is presented, then the block idles.
- The block never writes memory; any BRAM write enable is driven 0 by the integrating level.

Decomposition:
- Shared package: state encoding (S_IDLE, S_REQ, S_CAP, S_OUT), ADDR_W default, opcode pattern constants for the length classes.
- One natural sub-module: instr_len_decode (combinational, 8-bit opcode -> 2-bit length), reused later by the decoder and the disassembler debug path.

Test Plan:
- Reset mid-S_CAP with run=1 -> all outputs return to reset values immediately; after release, fetch restarts at RESET_PC=00.
- Memory 00:3E 42, run=1, mem_step every 4 cycles -> one bundle: opcode=3E, op_lo=42, op_hi=00, len=2, instr_pc=00, pc_out=02.
- Memory 02:C3 10 00, instr_ready held 0 for 5 cycles -> bundle (C3,10,00,len 3,pc 02) held stable and valid throughout; accepted on ready, pc_out=05.
- Opcode 32 at FE, operands at FF and 00 -> op_lo=mem[FF], op_hi=mem[00], pc_out=01 (wrap).
- pc_load=1, pc_new=10 asserted in S_REQ after the opcode byte of a 3-byte instruction, with a simultaneous mem_step -> partial discarded, no bundle, next mem_addr=10.
- Back-to-back NOP (00) stream with instr_ready=1 -> one bundle per 2 step periods; run dropped mid-stream -> the in-flight instruction completes, then mem_en stays 0.
